id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register and operand-forwarding front end for the execute stage.
- Captures decoded instructions and register-file reads from decode.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and interlocks one cycle on load-use.
- Drives the ALU operand/opcode inputs directly, with a valid/ready handshake toward EX/MEM.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/operand_fwd_mux.sv | 30 +++
 rtl/id_ex_operand_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the execute-stage front end
// ALU opcode groups (p_ALUop[3:2]), the hardwired-zero register address,
// and the operand forwarding source select.
package cpu_pkg;
    localparam logic [1:0] ALU_LOGIC = 2'b00;
    localparam logic [1:0] ALU_ARITH = 2'b01;
    localparam logic [1:0] ALU_COMP  = 2'b10;
    localparam logic [1:0] ALU_SHIFT = 2'b11;
    localparam logic [4:0] REG_ZERO  = 5'd0;
    typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: picks the freshest value of one source register
// Ports: addr/reg_data = source register and its held value;
//        mem_* / wb_*  = EX/MEM and MEM/WB write-back forwarding sources;
//        data          = forwarded operand.
// The younger MEM result beats WB; register 0 is never forwarded.
module operand_fwd_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] addr,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             mem_regwrite,
    input  logic [RADDR-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_regwrite,
    input  logic [RADDR-1:0] wb_rd_addr,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] data
);
    logic     nz;
    fwd_sel_e sel;
    always_comb begin
        nz   = addr != RADDR'(REG_ZERO);
        sel  = (nz && mem_regwrite && mem_rd_addr == addr) ? FWD_MEM :
               (nz && wb_regwrite && wb_rd_addr == addr)   ? FWD_WB  : FWD_REG;
        data = sel == FWD_MEM ? mem_result : sel == FWD_WB ? wb_result : reg_data;
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with operand forwarding and load-use interlock
// Ports: p_id_*  = decoded instruction and register-file reads (valid/ready);
//        p_mem_*, p_wb_* = forwarding sources; p_flush kills the held instruction;
//        p_ex_ready = downstream accept; p_valid/p_ALUop/p_SHAMT/p_A/p_B/
//        p_store_data/p_rd_addr/control bits = held instruction toward the ALU.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int RADDR = 5
) (
    input  logic             p_clk,
    input  logic             p_rst,
    input  logic             p_id_valid,
    output logic             p_id_ready,
    input  logic [3:0]       p_id_ALUop,
    input  logic [4:0]       p_id_SHAMT,
    input  logic [RADDR-1:0] p_id_rs_addr,
    input  logic [RADDR-1:0] p_id_rt_addr,
    input  logic [WIDTH-1:0] p_id_rs_data,
    input  logic [WIDTH-1:0] p_id_rt_data,
    input  logic [WIDTH-1:0] p_id_imm,
    input  logic             p_id_use_imm,
    input  logic [RADDR-1:0] p_id_rd_addr,
    input  logic             p_id_regwrite,
    input  logic             p_id_memread,
    input  logic             p_id_memwrite,
    input  logic             p_flush,
    input  logic             p_ex_ready,
    input  logic             p_mem_regwrite,
    input  logic [RADDR-1:0] p_mem_rd_addr,
    input  logic [WIDTH-1:0] p_mem_result,
    input  logic             p_wb_regwrite,
    input  logic [RADDR-1:0] p_wb_rd_addr,
    input  logic [WIDTH-1:0] p_wb_result,
    output logic             p_valid,
    output logic [3:0]       p_ALUop,
    output logic [4:0]       p_SHAMT,
    output logic [WIDTH-1:0] p_A,
    output logic [WIDTH-1:0] p_B,
    output logic [WIDTH-1:0] p_store_data,
    output logic [RADDR-1:0] p_rd_addr,
    output logic             p_regwrite,
    output logic             p_memread,
    output logic             p_memwrite
);
    logic             valid_q, valid_d, use_imm_q, use_imm_d;
    logic             regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [RADDR-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [WIDTH-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [WIDTH-1:0] rs_fwd, rt_fwd;
    logic             adv, hazard;

    always_comb begin
        adv        = ~valid_q | p_ex_ready;
        // A held load whose result a new instruction needs cannot be forwarded yet.
        hazard     = valid_q & memread_q & (rd_q != RADDR'(REG_ZERO)) & p_id_valid &
                     ((rd_q == p_id_rs_addr) | ((rd_q == p_id_rt_addr) & ~p_id_use_imm));
        p_id_ready = adv & ~hazard;
        valid_d    = valid_q;
        alu_op_d   = alu_op_q;
        shamt_d    = shamt_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        use_imm_d  = use_imm_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        if (p_flush || (adv && hazard)) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d    = p_id_valid;
            alu_op_d   = p_id_ALUop;
            shamt_d    = p_id_SHAMT;
            rs_d       = p_id_rs_addr;
            rt_d       = p_id_rt_addr;
            rs_data_d  = p_id_rs_data;
            rt_data_d  = p_id_rt_data;
            imm_d      = p_id_imm;
            use_imm_d  = p_id_use_imm;
            rd_d       = p_id_rd_addr;
            regwrite_d = p_id_regwrite;
            memread_d  = p_id_memread;
            memwrite_d = p_id_memwrite;
        end else begin
            // A WB value retiring during the stall would vanish from the bypass next cycle.
            rs_data_d = (p_wb_regwrite && p_wb_rd_addr != RADDR'(REG_ZERO) && p_wb_rd_addr == rs_q) ? p_wb_result : rs_data_q;
            rt_data_d = (p_wb_regwrite && p_wb_rd_addr != RADDR'(REG_ZERO) && p_wb_rd_addr == rt_q) ? p_wb_result : rt_data_q;
        end
    end

    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            valid_q    <= 1'b0;
            alu_op_q   <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            alu_op_q   <= alu_op_d;
            shamt_q    <= shamt_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            use_imm_q  <= use_imm_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
        end
    end

    operand_fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_rs_fwd (
        .addr(rs_q), .reg_data(rs_data_q),
        .mem_regwrite(p_mem_regwrite), .mem_rd_addr(p_mem_rd_addr), .mem_result(p_mem_result),
        .wb_regwrite(p_wb_regwrite), .wb_rd_addr(p_wb_rd_addr), .wb_result(p_wb_result),
        .data(rs_fwd)
    );

    operand_fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_rt_fwd (
        .addr(rt_q), .reg_data(rt_data_q),
        .mem_regwrite(p_mem_regwrite), .mem_rd_addr(p_mem_rd_addr), .mem_result(p_mem_result),
        .wb_regwrite(p_wb_regwrite), .wb_rd_addr(p_wb_rd_addr), .wb_result(p_wb_result),
        .data(rt_fwd)
    );

    assign p_valid      = valid_q;
    assign p_ALUop      = alu_op_q;
    assign p_SHAMT      = shamt_q;
    assign p_A          = rs_fwd;
    assign p_B          = use_imm_q ? imm_q : rt_fwd;
    assign p_store_data = rt_fwd;
    assign p_rd_addr    = rd_q;
    assign p_regwrite   = valid_q & regwrite_q;
    assign p_memread    = valid_q & memread_q;
    assign p_memwrite   = valid_q & memwrite_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and random checks of the ID/EX operand stage against a behavioural model
module tb_id_ex_operand_stage;
    logic        p_clk, p_rst, p_id_valid, p_id_ready, p_id_use_imm;
    logic [3:0]  p_id_ALUop, p_ALUop;
    logic [4:0]  p_id_SHAMT, p_SHAMT, p_id_rs_addr, p_id_rt_addr, p_id_rd_addr;
    logic [63:0] p_id_rs_data, p_id_rt_data, p_id_imm;
    logic        p_id_regwrite, p_id_memread, p_id_memwrite, p_flush, p_ex_ready;
    logic        p_mem_regwrite, p_wb_regwrite;
    logic [4:0]  p_mem_rd_addr, p_wb_rd_addr, p_rd_addr;
    logic [63:0] p_mem_result, p_wb_result, p_A, p_B, p_store_data;
    logic        p_valid, p_regwrite, p_memread, p_memwrite;
    int total = 0, bad = 0;

    typedef struct {
        bit v, ui, rw, mr, mw;
        bit [3:0] op;
        bit [4:0] sh, rs, rt, rd;
        bit [63:0] rsd, rtd, imm;
    } instr_t;
    instr_t m;

    id_ex_operand_stage dut (
        .p_clk(p_clk), .p_rst(p_rst), .p_id_valid(p_id_valid), .p_id_ready(p_id_ready),
        .p_id_ALUop(p_id_ALUop), .p_id_SHAMT(p_id_SHAMT),
        .p_id_rs_addr(p_id_rs_addr), .p_id_rt_addr(p_id_rt_addr),
        .p_id_rs_data(p_id_rs_data), .p_id_rt_data(p_id_rt_data),
        .p_id_imm(p_id_imm), .p_id_use_imm(p_id_use_imm), .p_id_rd_addr(p_id_rd_addr),
        .p_id_regwrite(p_id_regwrite), .p_id_memread(p_id_memread), .p_id_memwrite(p_id_memwrite),
        .p_flush(p_flush), .p_ex_ready(p_ex_ready),
        .p_mem_regwrite(p_mem_regwrite), .p_mem_rd_addr(p_mem_rd_addr), .p_mem_result(p_mem_result),
        .p_wb_regwrite(p_wb_regwrite), .p_wb_rd_addr(p_wb_rd_addr), .p_wb_result(p_wb_result),
        .p_valid(p_valid), .p_ALUop(p_ALUop), .p_SHAMT(p_SHAMT), .p_A(p_A), .p_B(p_B),
        .p_store_data(p_store_data), .p_rd_addr(p_rd_addr),
        .p_regwrite(p_regwrite), .p_memread(p_memread), .p_memwrite(p_memwrite)
    );

    initial p_clk = 0;
    always #5 p_clk = ~p_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [63:0] fwd(input bit [4:0] a, input bit [63:0] d);
        if (a != 0 && p_mem_regwrite && p_mem_rd_addr == a) return p_mem_result;
        if (a != 0 && p_wb_regwrite && p_wb_rd_addr == a) return p_wb_result;
        return d;
    endfunction

    task automatic idle();
        p_id_valid = 0; p_id_ALUop = 0; p_id_SHAMT = 0; p_id_rs_addr = 0; p_id_rt_addr = 0;
        p_id_rs_data = 0; p_id_rt_data = 0; p_id_imm = 0; p_id_use_imm = 0; p_id_rd_addr = 0;
        p_id_regwrite = 0; p_id_memread = 0; p_id_memwrite = 0; p_flush = 0; p_ex_ready = 1;
        p_mem_regwrite = 0; p_mem_rd_addr = 0; p_mem_result = 0;
        p_wb_regwrite = 0; p_wb_rd_addr = 0; p_wb_result = 0;
    endtask

    task automatic issue(input bit [3:0] op, input bit [4:0] rs, input bit [63:0] rsd,
                         input bit [4:0] rt, input bit [63:0] rtd, input bit [4:0] rd, input bit mr);
        p_id_valid = 1; p_id_ALUop = op; p_id_rs_addr = rs; p_id_rs_data = rsd;
        p_id_rt_addr = rt; p_id_rt_data = rtd; p_id_rd_addr = rd;
        p_id_regwrite = 1; p_id_memread = mr;
    endtask

    // Compare everything against the model, then advance one clock and update the model.
    task automatic cyc();
        bit haz, adv;
        #1;
        adv = !m.v || p_ex_ready;
        haz = m.v && m.mr && m.rd != 0 && p_id_valid &&
              (m.rd == p_id_rs_addr || (m.rd == p_id_rt_addr && !p_id_use_imm));
        chk("ready", p_id_ready, adv && !haz);
        chk("valid", p_valid, m.v);
        chk("regwrite", p_regwrite, m.v && m.rw);
        chk("memread", p_memread, m.v && m.mr);
        chk("memwrite", p_memwrite, m.v && m.mw);
        if (m.v) begin
            chk("aluop", p_ALUop, m.op);
            chk("shamt", p_SHAMT, m.sh);
            chk("rd", p_rd_addr, m.rd);
            chk("A", p_A, fwd(m.rs, m.rsd));
            chk("B", p_B, m.ui ? m.imm : fwd(m.rt, m.rtd));
            chk("store", p_store_data, fwd(m.rt, m.rtd));
        end
        if (p_flush || (adv && haz)) m.v = 0;
        else if (adv) begin
            m.v = p_id_valid; m.op = p_id_ALUop; m.sh = p_id_SHAMT;
            m.rs = p_id_rs_addr; m.rt = p_id_rt_addr; m.rsd = p_id_rs_data; m.rtd = p_id_rt_data;
            m.imm = p_id_imm; m.ui = p_id_use_imm; m.rd = p_id_rd_addr;
            m.rw = p_id_regwrite; m.mr = p_id_memread; m.mw = p_id_memwrite;
        end else begin
            if (p_wb_regwrite && p_wb_rd_addr != 0 && p_wb_rd_addr == m.rs) m.rsd = p_wb_result;
            if (p_wb_regwrite && p_wb_rd_addr != 0 && p_wb_rd_addr == m.rt) m.rtd = p_wb_result;
        end
        @(posedge p_clk);
        #1;
    endtask

    initial begin
        m = '{default: 0};
        idle();
        p_rst = 1;
        #2;
        chk("rst_valid", p_valid, 0);
        chk("rst_A", p_A, 0);
        chk("rst_B", p_B, 0);
        chk("rst_store", p_store_data, 0);
        chk("rst_aluop", p_ALUop, 0);
        chk("rst_ready", p_id_ready, 1);
        @(posedge p_clk); #1;
        p_rst = 0;

        issue(4'b0100, 5'd1, 64'd5, 5'd2, 64'd7, 5'd3, 0);
        cyc();
        idle();
        #1;
        chk("add_A", p_A, 5);
        chk("add_B", p_B, 7);
        chk("add_valid", p_valid, 1);
        chk("add_rw", p_regwrite, 1);

        p_mem_regwrite = 1; p_mem_rd_addr = 1; p_mem_result = 64'h10;
        p_wb_regwrite = 1; p_wb_rd_addr = 1; p_wb_result = 64'h20;
        #1 chk("fwd_mem_wins", p_A, 64'h10);
        p_mem_regwrite = 0;
        #1 chk("fwd_wb", p_A, 64'h20);
        idle();
        issue(4'b0100, 5'd0, 64'd0, 5'd2, 64'd7, 5'd3, 0);
        cyc();
        idle();
        p_mem_regwrite = 1; p_mem_rd_addr = 0; p_mem_result = 64'hdead;
        #1 chk("fwd_r0", p_A, 0);

        idle();
        issue(4'b0100, 5'd0, 64'd0, 5'd0, 64'd0, 5'd4, 1);
        p_id_use_imm = 1; p_id_imm = 64'd8;
        cyc();
        idle();
        issue(4'b0101, 5'd4, 64'd0, 5'd0, 64'd0, 5'd5, 0);
        #1 chk("lu_ready", p_id_ready, 0);
        cyc();
        #1;
        chk("lu_bubble", p_valid, 0);
        chk("lu_bubble_rw", p_regwrite, 0);
        chk("lu_ready2", p_id_ready, 1);
        cyc();
        idle();
        p_wb_regwrite = 1; p_wb_rd_addr = 4; p_wb_result = 64'h99;
        #1;
        chk("lu_A", p_A, 64'h99);
        chk("lu_valid", p_valid, 1);

        idle();
        issue(4'b0000, 5'd1, 64'h11, 5'd2, 64'd0, 5'd6, 0);
        cyc();
        idle();
        p_ex_ready = 0;
        p_id_valid = 1; p_id_rs_addr = 9;
        p_wb_regwrite = 1; p_wb_rd_addr = 2; p_wb_result = 64'h55;
        #1 chk("st_ready", p_id_ready, 0);
        cyc();
        p_wb_regwrite = 0;
        #1;
        chk("st_B", p_B, 64'h55);
        chk("st_valid", p_valid, 1);
        cyc();
        cyc();
        chk("st_B3", p_B, 64'h55);
        chk("st_rd", p_rd_addr, 6);

        p_flush = 1; p_id_rd_addr = 7; p_id_regwrite = 1;
        cyc();
        p_flush = 0; p_id_valid = 0;
        #1;
        chk("fl_valid", p_valid, 0);
        chk("fl_rd", p_rd_addr, 6);
        chk("fl_rw", p_regwrite, 0);

        idle();
        issue(4'b0100, 5'd1, 64'h77, 5'd0, 64'd0, 5'd8, 0);
        cyc();
        p_ex_ready = 0; p_id_valid = 0;
        #1;
        chk("pre_rst_A", p_A, 64'h77);
        p_rst = 1;
        #1;
        chk("mid_rst_valid", p_valid, 0);
        chk("mid_rst_A", p_A, 0);
        chk("mid_rst_rw", p_regwrite, 0);
        m = '{default: 0};
        @(posedge p_clk); #1;
        p_rst = 0;
        idle();
        #1 chk("post_rst_ready", p_id_ready, 1);

        for (int i = 0; i < 400; i++) begin
            p_id_valid = $urandom_range(0, 3) != 0;
            p_id_ALUop = 4'($urandom);
            p_id_SHAMT = 5'($urandom);
            p_id_rs_addr = 5'($urandom_range(0, 3));
            p_id_rt_addr = 5'($urandom_range(0, 3));
            p_id_rd_addr = 5'($urandom_range(0, 3));
            p_id_rs_data = {$urandom, $urandom};
            p_id_rt_data = {$urandom, $urandom};
            p_id_imm = {$urandom, $urandom};
            p_id_use_imm = $urandom_range(0, 2) == 0;
            p_id_regwrite = $urandom_range(0, 1);
            p_id_memread = $urandom_range(0, 2) == 0;
            p_id_memwrite = $urandom_range(0, 4) == 0;
            p_flush = $urandom_range(0, 15) == 0;
            p_ex_ready = $urandom_range(0, 3) != 0;
            p_mem_regwrite = $urandom_range(0, 1);
            p_mem_rd_addr = 5'($urandom_range(0, 3));
            p_mem_result = {$urandom, $urandom};
            p_wb_regwrite = $urandom_range(0, 1);
            p_wb_rd_addr = 5'($urandom_range(0, 3));
            p_wb_result = {$urandom, $urandom};
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
